// File: rtl/game_pkg.sv
// game_pkg: shared game state encoding and timing/speed constants for game_ctrl, T-rex and obstacle blocks
package game_pkg;
  typedef enum logic [1:0] {WAITING = 2'd0, PLAYING = 2'd1, CRASHED = 2'd2, RESTART = 2'd3} game_state_t;
  localparam int CLK_FREQ = 100_000_000;
  localparam int FPS = 60;
  localparam int CLK_PER_FRAME = CLK_FREQ / FPS;
  localparam int START_SPEED = 6;
  localparam int MAX_SPEED = 13;
endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: game controller bus (btn_jump, crash in; frame_tick, timer, speed, jump, game_rst, score, game_state out)
interface game_ctrl_if;
  import game_pkg::*;
  logic btn_jump;
  logic crash;
  logic frame_tick;
  logic [5:0] timer;
  logic [3:0] speed;
  logic jump;
  logic game_rst;
  logic [15:0] score;
  game_state_t game_state;
  modport master (output btn_jump, crash, input frame_tick, timer, speed, jump, game_rst, score, game_state);
  modport slave (input btn_jump, crash, output frame_tick, timer, speed, jump, game_rst, score, game_state);
endinterface

// File: rtl/game_ctrl_btn_sync.sv
// btn_sync: two-FF synchronizer plus rising-edge pulse (clk, rst, in -> rise)
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic [2:0] s;
  always_ff @(posedge clk) s <= rst ? '0 : {s[1:0], in};
  assign rise = s[1] & ~s[2];
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: frame tick/timer, game FSM, jump pulse, speed ramp, score and soft reset (clk, rst, bus slave)
module game_ctrl import game_pkg::*; #(
  parameter int CLK_PER_FRAME = game_pkg::CLK_PER_FRAME,
  parameter int START_SPEED = game_pkg::START_SPEED,
  parameter int MAX_SPEED = game_pkg::MAX_SPEED,
  parameter int SPEEDUP_FRAMES = 600,
  parameter int RESTART_DELAY = 45
) (
  input logic clk,
  input logic rst,
  game_ctrl_if.slave bus
);
  localparam int CW = $clog2(CLK_PER_FRAME);
  localparam int SW = $clog2(SPEEDUP_FRAMES + 1);
  localparam int DW = $clog2(RESTART_DELAY + 1);
  logic [CW-1:0] clk_cnt;
  logic [SW-1:0] spd_cnt;
  logic [DW-1:0] dly;
  game_state_t state;
  logic jump_pend, rise, tick, jump_go, restart_go, delay_met, speed_step;
  logic [16:0] sum;
  btn_sync u_btn (.clk(clk), .rst(rst), .in(bus.btn_jump), .rise(rise));
  assign tick = clk_cnt == CW'(CLK_PER_FRAME - 1);
  assign delay_met = dly == DW'(RESTART_DELAY);
  // crash wins over a jump on the same tick
  assign jump_go = tick & jump_pend & (state == WAITING | (state == PLAYING & ~bus.crash));
  assign restart_go = tick & jump_pend & state == CRASHED & delay_met;
  assign speed_step = spd_cnt == SW'(SPEEDUP_FRAMES - 1);
  assign sum = {1'b0, bus.score} + 17'(bus.speed);
  assign bus.frame_tick = tick;
  assign bus.jump = jump_go;
  assign bus.game_state = state;
  always_ff @(posedge clk)
    if (rst) begin
      clk_cnt <= '0;
      bus.timer <= '0;
      state <= WAITING;
      bus.speed <= 4'(START_SPEED);
      bus.score <= '0;
      bus.game_rst <= 1'b0;
      spd_cnt <= '0;
      dly <= '0;
      jump_pend <= 1'b0;
    end else begin
      clk_cnt <= tick ? '0 : clk_cnt + 1'b1;
      if (tick) bus.timer <= bus.timer == 6'd59 ? '0 : bus.timer + 1'b1;
      // presses during the post-crash delay are discarded
      jump_pend <= state == CRASHED & ~delay_met ? 1'b0 : rise | (jump_pend & ~jump_go & ~restart_go);
      bus.game_rst <= restart_go;
      case (state)
        WAITING: if (jump_go) begin
          state <= PLAYING;
          bus.speed <= 4'(START_SPEED);
          bus.score <= '0;
          spd_cnt <= '0;
        end
        PLAYING: if (bus.crash) begin
          state <= CRASHED;
          dly <= '0;
        end else if (tick) begin
          bus.score <= sum[16] ? '1 : sum[15:0];
          spd_cnt <= speed_step ? '0 : spd_cnt + 1'b1;
          if (speed_step && bus.speed < 4'(MAX_SPEED)) bus.speed <= bus.speed + 1'b1;
        end
        CRASHED: begin
          if (tick & ~delay_met) dly <= dly + 1'b1;
          if (restart_go) state <= RESTART;
        end
        RESTART: begin
          state <= WAITING;
          bus.speed <= 4'(START_SPEED);
          bus.score <= '0;
          spd_cnt <= '0;
        end
      endcase
    end
endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the T-rex runner. Generates the 60 FPS frame tick and the 0–59 `timer` phase used by the T-rex animation, and owns the game state (waiting, playing, crashed, restart). Also converts the raw jump button into a frame-aligned `jump` pulse, ramps `speed` over time, accumulates distance `score`, and issues a one-cycle soft reset to the character, obstacle and ground blocks on restart.

## Interface

Parameters:
- `CLK_PER_FRAME`, 1_666_666: clk cycles per frame (100 MHz / 60).
- `START_SPEED`, 6: speed loaded on game start.
- `MAX_SPEED`, 13: speed saturation value.
- `SPEEDUP_FRAMES`, 600: playing frames between speed increments.
- `RESTART_DELAY`, 45: frames after crash before restart is accepted.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_jump`  in  1  raw, asynchronous jump button level.
- `crash`  in  1  collision flag from the collision detector; level, sampled every cycle.
- `frame_tick`  out  1  one-cycle pulse at each frame boundary.
- `timer`  out  6  frame phase, 0..59.
- `speed`  out  4  current scroll speed.
- `jump`  out  1  one-cycle jump request, asserted only with `frame_tick`.
- `game_rst`  out  1  one-cycle soft reset for gameplay blocks.
- `score`  out  16  distance accumulated, saturating.
- `game_state`  out  2  `game_state_t` encoding.

## Operation

- Button path:
  - Two-FF synchronizer feeds a rising-edge detector.
  - A detected edge sets `jump_pend`.
  - `jump_pend` clears when consumed.
- Frame counter:
  - `clk_cnt` counts 0..CLK_PER_FRAME-1 and wraps.
  - `frame_tick` = 1 in the cycle `clk_cnt` == CLK_PER_FRAME-1.
  - `timer` increments on `frame_tick` and wraps 59→0.
  - The frame counter and `timer` run in all states.
- States of `game_state_t`: WAITING=0, PLAYING=1, CRASHED=2, RESTART=3.
- WAITING:
  - On `frame_tick` with `jump_pend`: assert `jump` and clear `jump_pend`.
  - Load `speed` = START_SPEED, `score` = 0 and the speed-up counter = 0.
  - Go to PLAYING.
- PLAYING, on each `frame_tick`:
  - Add `speed` to `score`, saturating at 0xFFFF.
  - Advance the speed-up counter. When it reaches SPEEDUP_FRAMES-1, it resets and `speed` increments, saturating at MAX_SPEED.
  - If `jump_pend`: assert `jump` and clear `jump_pend`.
- PLAYING → CRASHED:
  - Taken in any cycle `crash` = 1, not only on a tick. `crash` has priority over a same-cycle jump.
  - `score` and `speed` freeze.
  - Load the delay counter with 0.
- CRASHED:
  - The delay counter increments on each `frame_tick`, saturating at RESTART_DELAY.
  - `jump_pend` is cleared every cycle while the delay counter < RESTART_DELAY, so early presses are discarded.
  - Once the delay is met: on `frame_tick` with `jump_pend`, clear `jump_pend` and go to RESTART. No `jump` pulse is issued.
- RESTART: lasts exactly one cycle with `game_rst` = 1, then WAITING.
- `crash` is ignored in WAITING, CRASHED and RESTART.

## Timing

- Reset values:
  - `frame_tick` = 0, `timer` = 0, `speed` = START_SPEED.
  - `jump` = 0, `game_rst` = 0, `score` = 0.
  - `game_state` = WAITING; all counters 0; sync FFs and `jump_pend` = 0.
- Button latency: edge to `jump_pend` set is 3 cycles. `jump` then asserts on the next `frame_tick`, or the same cycle if the tick coincides.
- All outputs are registered except `frame_tick` and `jump`. These two are combinational from registered state, so they align with the tick cycle.
- State change on tick: the new `game_state` is visible the cycle after the tick.
- `score`/`speed`/`timer` updates from a tick are visible the cycle after `frame_tick`.
- A second button edge while `jump_pend` = 1 has no effect; there is no queueing.
- `rst` mid-game overrides everything within one cycle. `game_rst` is not asserted by `rst`; gameplay blocks also take `rst` directly.

## Structure

- `game_pkg` holds:
  - `game_state_t`.
  - `CLK_FREQ`, `FPS`, `CLK_PER_FRAME`.
  - `START_SPEED`, `MAX_SPEED`.
- `game_pkg` is shared with the T-rex and obstacle blocks.
- One sub-module, `btn_sync`: two-FF synchronizer plus rising-edge pulse, reusable for a future duck button.

## Test plan

All scenarios use `CLK_PER_FRAME`=10, `SPEEDUP_FRAMES`=4, `RESTART_DELAY`=3.

- Frame counter: run 600 cycles after reset → `frame_tick` every 10 cycles; `timer` steps 0..59 then back to 0; state stays WAITING; `jump` never asserted.
- Start: press button at cycle 2 → `jump` high only in the cycle `frame_tick` is high at cycle 9; `game_state` = PLAYING from cycle 10; `speed` = 6.
- Speed and score: from start, play 40 frames → `speed` steps 6,7,… reaching 13 and holding; `score` equals the sum of per-frame speeds; force `score` near 0xFFFF → saturates at 0xFFFF.
- Crash: assert `crash` mid-frame with a button press in the same frame → CRASHED next cycle; no `jump`; `score` and `speed` frozen.
- Restart timing: press at 1 frame post-crash → ignored. Press at 4 frames → on the next tick, RESTART for one cycle with `game_rst` = 1, then WAITING with `score` = 0.
- Reset mid-game: assert `rst` in PLAYING with `jump_pend` set → all outputs return to reset values next cycle; `game_rst` = 0; no `jump` is issued afterward.
